ttl_bcd_updown_counter: RTL and testbench
=========================================

Name: ttl_bcd_updown_counter

Overview:
Parametrised successor to the single-decade synchronous counter. It is an N-digit synchronous up/down modulus counter, BCD by default, with internal digit cascading. It keeps the TTL-style control set: active-low parallel load, CEP/CET enables, terminal count. It adds direction control, synchronous clear, per-digit carry flags and deterministic recovery from illegal digit codes. It sits in the TTL-replacement library as the drop-in for chains of 74x160/190-class parts.

Parameters:
DIGITS, 4, number of cascaded digits (1..8)
DIGIT_W, 4, bits per digit
MODULUS, 10, per-digit modulus (2..2**DIGIT_W); digit counts 0..MODULUS-1

Ports:
clk  in  1  rising-edge clock
MR  in  1  asynchronous active-high master reset; clears all digits
SR  in  1  synchronous active-high clear
PE_n  in  1  synchronous active-low parallel load
CEP  in  1  count enable parallel
CET  in  1  count enable trickle; also gates TC
UD  in  1  direction: 1 = up, 0 = down
P  in  DIGITS*DIGIT_W  parallel load data; digit i at bits [i*DIGIT_W +: DIGIT_W]
Q  out  DIGITS*DIGIT_W  current count, same packing as P
TC  out  1  terminal count of the whole chain (combinational)
DTC  out  DIGITS  per-digit terminal flag (combinational, not gated by CET)

Behaviour:
- One clock (clk). Reset MR is asynchronous and active-high. While MR=1, Q=0, so TC=0 if UD=1 and TC=CET if UD=0, and DTC follows Q.
- Priority at each rising edge, given MR=0: SR=1 -> Q<=0; else PE_n=0 -> Q<=P (all digits, verbatim, illegal codes included); else CEP&CET=1 -> count step; else hold.
- SR and PE_n override CEP/CET/UD. SR overrides PE_n.
- Terminal value per digit:
  - up: MODULUS-1
  - down: 0
- DTC[i] = 1 when digit i equals its terminal value for the current UD. An illegal digit (value >= MODULUS) is never terminal.
- Digit enable: en[0] = CEP&CET; en[i] = en[i-1] & DTC[i-1]. This is a carry-lookahead AND chain, single cycle; there is no ripple latency.
- Count step for digit i when en[i]=1:
  - up: value MODULUS-1 -> 0; legal value v -> v+1
  - down: value 0 -> MODULUS-1; legal value v -> v-1
  - illegal value (>= MODULUS): up -> 0, down -> MODULUS-1. Recovery takes one step, and because the digit was not terminal it produces no carry into higher digits on that edge.
- Wrap-around: up from all digits MODULUS-1 goes to all zeros; down from all zeros goes to all MODULUS-1. There is no sticky overflow flag.
- TC = CET & (all DTC = 1). It is combinational on Q, UD and CET, and is independent of CEP (TTL semantics, for external cascading).
- A UD change takes effect on the next edge. DTC and TC change combinationally with UD.
- Latency: Q updates on the edge following a request. Load, clear and count all take 1 cycle.
- MR asserted mid-count: Q clears immediately, asynchronously. After MR deasserts, the first active edge obeys normal priority.
- Width rules: next-value arithmetic is done in DIGIT_W bits. When MODULUS = 2**DIGIT_W, no illegal codes exist and the recovery logic must reduce to plain wrap.

Decomposition:
- Shared package ttl_counter_pkg holds:
  - digit_dir_e (DIR_DOWN=0, DIR_UP=1)
  - function digit_terminal(value, dir, modulus)
  - function digit_next(value, dir, modulus), which returns the next value including illegal-code recovery
- One sub-module, ttl_counter_digit: a single DIGIT_W register with async MR, SR, load, enable, UD, and DTC output. The top instantiates DIGITS of these in a generate loop and builds the enable chain and TC.

Test Plan:
- DIGITS=2, MODULUS=10: MR pulse, then UD=1, CEP=CET=1. Q steps 00..09,10; at Q=99 TC=1; next edge Q=00, TC=0.
- Load P=0x00 with UD=0, then count. TC=1 at 00; next edge Q=99; next Q=98; DTC=2'b00 at 98.
- Load P=0x0C (digit0=12, illegal), UD=1, count. Next Q=0x00 (no carry into digit1); next Q=0x01. Repeat with UD=0: 0x0C -> 0x09.
- At Q=0x59 with UD=1, assert PE_n=0 and SR=1 with P=0x37. Q=0x00. Then SR=0, PE_n=0: Q=0x37. Then CEP=0, CET=1: Q holds and TC=0. Then Q=0x99, CEP=0: TC=1 while Q holds.
- Mid-count at Q=0x46, assert MR between edges. Q=0x00 immediately, without waiting for an edge, and stays 00 across edges while MR=1. After release, counting resumes 01, 02.
- DIGIT_W=4, MODULUS=16, DIGITS=1. Up count 0xF -> 0x0 with TC=1 at 0xF. Load 0xF with UD=0 steps 0xF -> 0xE, with no recovery path taken.

Source files
------------

// File: rtl/ttl_counter_pkg.sv
// Shared digit rules for the TTL-replacement counters: direction encoding, terminal test, next-value step.
// Pure combinational helpers; no latency, no flow control.
package ttl_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } digit_dir_e;

    // Values at or above the modulus are illegal codes and never count as terminal.
    function automatic logic digit_terminal(input logic [31:0]  value,
                                            input digit_dir_e   dir,
                                            input int unsigned  modulus);
        if (dir == DIR_UP) begin
            return value == (modulus - 32'd1);
        end
        return value == 32'd0;
    endfunction

    // Illegal codes recover to the wrap target of the current direction in one step.
    // With a full-range modulus no value can reach the recovery branch.
    function automatic logic [31:0] digit_next(input logic [31:0]  value,
                                               input digit_dir_e   dir,
                                               input int unsigned  modulus);
        if (dir == DIR_UP) begin
            return (value >= modulus - 32'd1) ? 32'd0 : value + 32'd1;
        end
        return (value == 32'd0 || value >= modulus) ? modulus - 32'd1 : value - 32'd1;
    endfunction

endpackage

// File: rtl/ttl_counter_digit.sv
// One counter decade: async clear, sync clear, parallel load, enabled up/down step, terminal flag.
// Q updates on the edge after a request (1 cycle); always accepts, no backpressure.
module ttl_counter_digit
    import ttl_counter_pkg::*;
#(
    parameter int          DIGIT_W = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sr,
    input  logic               load,
    input  logic               en,
    input  digit_dir_e         dir,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               dtc
);

    logic [DIGIT_W-1:0] q_next;

    assign q_next = DIGIT_W'(digit_next(32'(q), dir, MODULUS));
    assign dtc    = digit_terminal(32'(q), dir, MODULUS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (sr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/ttl_bcd_updown_counter.sv
// N-digit synchronous up/down modulus counter with TTL control set (PE_n, CEP/CET, TC) and per-digit carries.
// Load/clear/count land on the next edge (1 cycle); always accepts, no backpressure.
module ttl_bcd_updown_counter
    import ttl_counter_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int MODULUS = 10
) (
    input  logic                      clk,
    input  logic                      MR,
    input  logic                      SR,
    input  logic                      PE_n,
    input  logic                      CEP,
    input  logic                      CET,
    input  logic                      UD,
    input  logic [DIGITS*DIGIT_W-1:0] P,
    output logic [DIGITS*DIGIT_W-1:0] Q,
    output logic                      TC,
    output logic [DIGITS-1:0]         DTC
);

    logic [DIGITS-1:0] en;
    digit_dir_e        dir;

    assign dir = UD ? DIR_UP : DIR_DOWN;

    // Lookahead AND chain: every digit sees its enable in the same cycle.
    always_comb begin
        en    = '0;
        en[0] = CEP & CET;
        for (int i = 1; i < DIGITS; i++) begin
            en[i] = en[i-1] & DTC[i-1];
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        ttl_counter_digit #(
            .DIGIT_W (DIGIT_W),
            .MODULUS (MODULUS)
        ) u_digit (
            .clk  (clk),
            .rst  (MR),
            .sr   (SR),
            .load (~PE_n),
            .en   (en[gi]),
            .dir  (dir),
            .d    (P[gi*DIGIT_W +: DIGIT_W]),
            .q    (Q[gi*DIGIT_W +: DIGIT_W]),
            .dtc  (DTC[gi])
        );
    end

    // Independent of CEP so external stages can cascade on CET alone.
    assign TC = CET & (&DTC);

endmodule

// File: tb/tb_ttl_bcd_updown_counter.sv
// Bench for ttl_bcd_updown_counter: a 2-digit BCD instance and a 1-digit hex instance.
// Expected post-edge state is queued at drive time and checked by per-instance monitors.
module tb_ttl_bcd_updown_counter;

    typedef struct {
        logic [31:0] q;
        logic        tc;
        logic [7:0]  dtc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 2 BCD digits
    logic       mr_a, sr_a, pe_n_a, cep_a, cet_a, ud_a;
    logic [7:0] p_a, q_a;
    logic       tc_a;
    logic [1:0] dtc_a;

    // Instance B: 1 hex digit, full-range modulus
    logic       mr_b, sr_b, pe_n_b, cep_b, cet_b, ud_b;
    logic [3:0] p_b, q_b;
    logic       tc_b;
    logic [0:0] dtc_b;

    ttl_bcd_updown_counter #(.DIGITS(2), .DIGIT_W(4), .MODULUS(10)) dut_a (
        .clk(clk), .MR(mr_a), .SR(sr_a), .PE_n(pe_n_a), .CEP(cep_a), .CET(cet_a),
        .UD(ud_a), .P(p_a), .Q(q_a), .TC(tc_a), .DTC(dtc_a)
    );

    ttl_bcd_updown_counter #(.DIGITS(1), .DIGIT_W(4), .MODULUS(16)) dut_b (
        .clk(clk), .MR(mr_b), .SR(sr_b), .PE_n(pe_n_b), .CEP(cep_b), .CET(cet_b),
        .UD(ud_b), .P(p_b), .Q(q_b), .TC(tc_b), .DTC(dtc_b)
    );

    exp_t exp_a[$];
    exp_t exp_b[$];
    logic [31:0] qa_m, qb_m;
    int compared = 0;
    int failed   = 0;
    event ev_a, ev_b;

    // ---------------- reference model: counts treated as numbers in base m ----------------
    function automatic int digit_of(logic [31:0] q, int i, int w);
        return int'((q >> (i * w)) & ((32'd1 << w) - 32'd1));
    endfunction

    function automatic logic [31:0] model_next(logic [31:0] q, int nd, int m, int w,
                                               logic mr, logic sr, logic pe_n, logic cep,
                                               logic cet, logic ud, logic [31:0] p);
        int     dig[8];
        int     k;
        longint low, span;
        bit     carry;
        logic [31:0] r;
        if (mr || sr) return 32'd0;
        if (!pe_n) return 32'(longint'(p) & ((longint'(1) << (nd * w)) - 1));
        if (!(cep && cet)) return q;
        for (int i = 0; i < nd; i++) dig[i] = digit_of(q, i, w);
        // Digits below the lowest illegal one behave as an ordinary base-m number;
        // the illegal digit only changes when that number carries/borrows out.
        k = nd;
        for (int i = nd - 1; i >= 0; i--) if (dig[i] >= m) k = i;
        low  = 0;
        span = 1;
        for (int i = k - 1; i >= 0; i--) low = low * m + dig[i];
        for (int i = 0; i < k; i++) span = span * m;
        if (ud) begin
            carry = (low == span - 1);
            low   = (low + 1) % span;
        end else begin
            carry = (low == 0);
            low   = (low + span - 1) % span;
        end
        for (int i = 0; i < k; i++) begin
            dig[i] = int'(low % m);
            low    = low / m;
        end
        if (k < nd && carry) dig[k] = ud ? 0 : m - 1;
        r = '0;
        for (int i = 0; i < nd; i++) r = r | (32'(dig[i]) << (i * w));
        return r;
    endfunction

    function automatic logic [7:0] model_dtc(logic [31:0] q, int nd, int m, int w, logic ud);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) r[i] = ud ? (digit_of(q, i, w) == m - 1) : (digit_of(q, i, w) == 0);
        return r;
    endfunction

    function automatic logic model_tc(logic [31:0] q, int nd, int m, int w, logic ud, logic cet);
        return cet && (model_dtc(q, nd, m, w, ud) == 8'((1 << nd) - 1));
    endfunction

    // ---------------- scoreboard push ----------------
    task automatic push_a();
        exp_t e;
        e.q   = qa_m;
        e.tc  = model_tc(qa_m, 2, 10, 4, ud_a, cet_a);
        e.dtc = model_dtc(qa_m, 2, 10, 4, ud_a);
        exp_a.push_back(e);
    endtask

    task automatic push_b();
        exp_t e;
        e.q   = qb_m;
        e.tc  = model_tc(qb_m, 1, 16, 4, ud_b, cet_b);
        e.dtc = model_dtc(qb_m, 1, 16, 4, ud_b);
        exp_b.push_back(e);
    endtask

    task automatic step_a(logic mr, logic sr, logic pe_n, logic cep, logic cet, logic ud, logic [7:0] p);
        @(negedge clk);
        mr_a = mr; sr_a = sr; pe_n_a = pe_n; cep_a = cep; cet_a = cet; ud_a = ud; p_a = p;
        qa_m = model_next(qa_m, 2, 10, 4, mr, sr, pe_n, cep, cet, ud, 32'(p));
        push_a();
    endtask

    task automatic step_b(logic mr, logic sr, logic pe_n, logic cep, logic cet, logic ud, logic [3:0] p);
        @(negedge clk);
        mr_b = mr; sr_b = sr; pe_n_b = pe_n; cep_b = cep; cet_b = cet; ud_b = ud; p_b = p;
        qb_m = model_next(qb_m, 1, 16, 4, mr, sr, pe_n, cep, cet, ud, 32'(p));
        push_b();
    endtask

    // Raise MR between edges; the check fires before any further edge.
    task automatic mid_mr_a();
        @(negedge clk);
        #2;
        mr_a = 1'b1;
        qa_m = '0;
        push_a();
        -> ev_a;
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        compared++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, got, want);
        end
    endtask

    // ---------------- monitors ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or ev_a);
            #1;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                chk("a_q",   32'(q_a),   e.q);
                chk("a_tc",  32'(tc_a),  32'(e.tc));
                chk("a_dtc", 32'(dtc_a), 32'(e.dtc[1:0]));
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or ev_b);
            #1;
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                chk("b_q",   32'(q_b),   e.q);
                chk("b_tc",  32'(tc_b),  32'(e.tc));
                chk("b_dtc", 32'(dtc_b), 32'(e.dtc[0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        mr_a = 1'b1; sr_a = 1'b0; pe_n_a = 1'b1; cep_a = 1'b1; cet_a = 1'b1; ud_a = 1'b1; p_a = '0;
        mr_b = 1'b1; sr_b = 1'b0; pe_n_b = 1'b1; cep_b = 1'b1; cet_b = 1'b1; ud_b = 1'b0; p_b = '0;
        qa_m = '0;
        qb_m = '0;
        #2;
        push_a(); -> ev_a;
        push_b(); -> ev_b;

        // Up count through the full 2-digit range and wrap
        repeat (100) step_a(0, 0, 1, 1, 1, 1, 8'h00);
        // Down from 00 wraps to 99
        step_a(0, 0, 0, 1, 1, 0, 8'h00);
        repeat (2) step_a(0, 0, 1, 1, 1, 0, 8'h00);
        // Illegal low digit recovery, both directions
        step_a(0, 0, 0, 1, 1, 1, 8'h0C);
        repeat (2) step_a(0, 0, 1, 1, 1, 1, 8'h00);
        step_a(0, 0, 0, 1, 1, 0, 8'h0C);
        step_a(0, 0, 1, 1, 1, 0, 8'h00);
        // Priority: SR over PE_n, then load, hold with CEP low, TC with CEP low
        step_a(0, 0, 0, 1, 1, 1, 8'h59);
        step_a(0, 1, 0, 1, 1, 1, 8'h37);
        step_a(0, 0, 0, 1, 1, 1, 8'h37);
        repeat (2) step_a(0, 0, 1, 0, 1, 1, 8'h00);
        step_a(0, 0, 0, 1, 1, 1, 8'h99);
        repeat (2) step_a(0, 0, 1, 0, 1, 1, 8'h00);
        // Asynchronous MR mid-count
        step_a(0, 0, 0, 1, 1, 1, 8'h40);
        repeat (6) step_a(0, 0, 1, 1, 1, 1, 8'h00);
        mid_mr_a();
        repeat (2) step_a(1, 0, 1, 1, 1, 1, 8'h00);
        repeat (2) step_a(0, 0, 1, 1, 1, 1, 8'h00);
        // Randomized traffic, including illegal codes in either digit
        repeat (300) begin
            step_a(1'b0, ($urandom_range(15) == 0), ($urandom_range(7) != 0),
                   ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                   1'($urandom_range(1)), 8'($urandom));
        end
        step_a(1, 0, 1, 1, 1, 1, 8'h00);

        // Full-range modulus instance
        repeat (17) step_b(0, 0, 1, 1, 1, 1, 4'h0);
        step_b(0, 0, 0, 1, 1, 0, 4'hF);
        repeat (2) step_b(0, 0, 1, 1, 1, 0, 4'h0);
        repeat (100) begin
            step_b(1'b0, ($urandom_range(15) == 0), ($urandom_range(7) != 0),
                   ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                   1'($urandom_range(1)), 4'($urandom));
        end

        repeat (2) @(negedge clk);
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", exp_a.size(), exp_b.size());
        end
        if (compared == 0) begin
            failed++;
            $display("FAIL activity: got 0 comparisons, want more than 0");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
